// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch FSM states, IF/ID payload, PC reset default.
package cpu_types_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned IMM_W   = 16;
    localparam int unsigned JADDR_W = 26;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    localparam word_t PC_INIT_DEFAULT = 32'h0000_0000;

    // Instruction word plus its fall-through PC, carried from IF to ID.
    typedef struct packed {
        word_t instr;
        word_t npc;
    } if_id_t;

    // Sign-extended 16-bit word offset converted to a byte offset.
    function automatic word_t branch_offset(input logic [IMM_W-1:0] imm);
        return {{(WORD_W - IMM_W - 2){imm[IMM_W-1]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction memory port, ID-stage feedback, IF/ID outputs.
// With FETCH_STATS_EN defined the fetch/miss counters are added.
interface fetch_unit_if;
    import cpu_types_pkg::*;

    logic               ihit;
    word_t              imemload;
    logic               imemREN;
    word_t              imemaddr;

    logic               branch;
    logic               beq;
    logic               bne;
    logic               jump;
    logic               jal;
    logic               jr;
    logic               halt;
    logic               zero;
    logic [IMM_W-1:0]   imm16;
    logic [JADDR_W-1:0] jaddr;
    word_t              rdat1;
    logic               stall;

    word_t              instr_id;
    word_t              npc_id;
    logic               valid_id;
    logic               halted;
`ifdef FETCH_STATS_EN
    word_t              fetch_cnt;
    word_t              miss_cnt;
`endif

    // Fetch unit side.
    modport master (
        input  ihit, imemload, branch, beq, bne, jump, jal, jr, halt, zero,
               imm16, jaddr, rdat1, stall,
        output imemREN, imemaddr, instr_id, npc_id, valid_id, halted
`ifdef FETCH_STATS_EN
        , output fetch_cnt, miss_cnt
`endif
    );

    // Memory / decode / system side.
    modport slave (
        output ihit, imemload, branch, beq, bne, jump, jal, jr, halt, zero,
               imm16, jaddr, rdat1, stall,
        input  imemREN, imemaddr, instr_id, npc_id, valid_id, halted
`ifdef FETCH_STATS_EN
        , input fetch_cnt, miss_cnt
`endif
    );

endinterface

// File: rtl/npc_calc.sv
// Redirect detection and target selection for the instruction sitting in ID.
module npc_calc
    import cpu_types_pkg::*;
(
    input  logic               valid_id,
    input  logic               branch,
    input  logic               beq,
    input  logic               bne,
    input  logic               jump,
    input  logic               jal,
    input  logic               jr,
    input  logic               zero,
    input  logic [IMM_W-1:0]   imm16,
    input  logic [JADDR_W-1:0] jaddr,
    input  word_t              rdat1,
    input  word_t              npc_id,
    output logic               redirect_c,
    output word_t              target_c
);

    logic taken_c;

    assign taken_c = branch & ((beq & zero) | (bne & ~zero));

    // Priority: jr > jump/jal > taken branch; nothing redirects from an empty ID slot.
    always_comb begin
        redirect_c = 1'b0;
        target_c   = '0;
        if (valid_id) begin
            if (jr) begin
                redirect_c = 1'b1;
                target_c   = rdat1;
            end else if (jump | jal) begin
                redirect_c = 1'b1;
                target_c   = {npc_id[WORD_W-1:WORD_W-4], jaddr, 2'b00};
            end else if (taken_c) begin
                redirect_c = 1'b1;
                target_c   = npc_id + branch_offset(imm16);
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Single-stage instruction fetch with IF/ID register, redirect squash and sticky halt.
// Optional FETCH_STATS_EN adds fetch_cnt / miss_cnt counters.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = PC_INIT_DEFAULT
) (
    input  logic         CLK,
    input  logic         RST,
    fetch_unit_if.master bus
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    if_id_t       ifid_q, ifid_d;
    logic         valid_q, valid_d;
    logic         halted_q, halted_d;
    logic         ren_q, ren_d;
    logic         redirect_c;
    word_t        target_c;
    word_t        pc_plus4_c;
`ifdef FETCH_STATS_EN
    word_t        fetch_cnt_q, fetch_cnt_d;
    word_t        miss_cnt_q, miss_cnt_d;
`endif

    assign pc_plus4_c = pc_q + 32'd4;

    npc_calc u_npc_calc (
        .valid_id   (valid_q),
        .branch     (bus.branch),
        .beq        (bus.beq),
        .bne        (bus.bne),
        .jump       (bus.jump),
        .jal        (bus.jal),
        .jr         (bus.jr),
        .zero       (bus.zero),
        .imm16      (bus.imm16),
        .jaddr      (bus.jaddr),
        .rdat1      (bus.rdat1),
        .npc_id     (ifid_q.npc),
        .redirect_c (redirect_c),
        .target_c   (target_c)
    );

    // Next-state and next-register values; everything holds unless FETCH advances.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ifid_d   = ifid_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        ren_d    = ren_q;
`ifdef FETCH_STATS_EN
        fetch_cnt_d = fetch_cnt_q;
        miss_cnt_d  = miss_cnt_q;
`endif
        case (state_q)
            FETCH: begin
                if (!bus.stall) begin
`ifdef FETCH_STATS_EN
                    if (!bus.ihit) miss_cnt_d = miss_cnt_q + 32'd1;
`endif
                    if (valid_q && bus.halt) begin
                        state_d  = HALTED;
                        valid_d  = 1'b0;
                        halted_d = 1'b1;
                        ren_d    = 1'b0;
                    end else if (redirect_c) begin
                        pc_d    = target_c;
                        valid_d = 1'b0;
                    end else if (bus.ihit) begin
                        pc_d    = pc_plus4_c;
                        ifid_d  = '{instr: bus.imemload, npc: pc_plus4_c};
                        valid_d = 1'b1;
`ifdef FETCH_STATS_EN
                        fetch_cnt_d = fetch_cnt_q + 32'd1;
`endif
                    end else begin
                        valid_d = 1'b0;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= FETCH;
            pc_q     <= PC_INIT;
            ifid_q   <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            ren_q    <= 1'b1;
`ifdef FETCH_STATS_EN
            fetch_cnt_q <= '0;
            miss_cnt_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ifid_q   <= ifid_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            ren_q    <= ren_d;
`ifdef FETCH_STATS_EN
            fetch_cnt_q <= fetch_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
`endif
        end
    end

    assign bus.imemREN  = ren_q;
    assign bus.imemaddr = pc_q;
    assign bus.instr_id = ifid_q.instr;
    assign bus.npc_id   = ifid_q.npc;
    assign bus.valid_id = valid_q;
    assign bus.halted   = halted_q;
`ifdef FETCH_STATS_EN
    assign bus.fetch_cnt = fetch_cnt_q;
    assign bus.miss_cnt  = miss_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios plus randomized traffic
// against an architectural PC model kept in the bench.
module tb_fetch_unit;
    import cpu_types_pkg::*;

    localparam word_t TB_PC_INIT = 32'h0000_0000;

    typedef struct {
        bit          rst;
        bit          ihit;
        bit          stall;
        bit          branch;
        bit          beq;
        bit          bne;
        bit          jump;
        bit          jal;
        bit          jr;
        bit          halt;
        bit          zero;
        logic [15:0] imm16;
        logic [25:0] jaddr;
        word_t       rdat1;
    } stim_t;

    typedef struct {
        word_t instr;
        word_t npc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(.PC_INIT(TB_PC_INIT)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int    n_cmp = 0;
    int    n_bad = 0;
    exp_t  sb_q[$];

    // Architectural model state (value after the most recent clock edge).
    word_t m_pc     = TB_PC_INIT;
    word_t m_npc    = '0;
    bit    m_valid  = 1'b0;
    bit    m_halted = 1'b0;
`ifdef FETCH_STATS_EN
    word_t m_fetch  = '0;
    word_t m_miss   = '0;
`endif

    function automatic word_t mem_word(input word_t a);
        return (a * 32'h9E37_79B1) + 32'h1234_5677;
    endfunction

    task automatic check32(input string name, input word_t act, input word_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    // Apply one cycle of stimulus, advance the model across the edge, then check.
    task automatic step(input stim_t s);
        int off;
        rst          = s.rst;
        bus.ihit     = s.ihit;
        bus.stall    = s.stall;
        bus.branch   = s.branch;
        bus.beq      = s.beq;
        bus.bne      = s.bne;
        bus.jump     = s.jump;
        bus.jal      = s.jal;
        bus.jr       = s.jr;
        bus.halt     = s.halt;
        bus.zero     = s.zero;
        bus.imm16    = s.imm16;
        bus.jaddr    = s.jaddr;
        bus.rdat1    = s.rdat1;
        bus.imemload = mem_word(m_pc);

        if (s.rst) begin
            m_pc = TB_PC_INIT; m_npc = '0; m_valid = 0; m_halted = 0;
`ifdef FETCH_STATS_EN
            m_fetch = '0; m_miss = '0;
`endif
            sb_q.delete();
        end else if (!m_halted && !s.stall) begin
`ifdef FETCH_STATS_EN
            if (!s.ihit) m_miss = m_miss + 1;
`endif
            if (m_valid && s.halt) begin
                m_halted = 1; m_valid = 0;
            end else if (m_valid && s.jr) begin
                m_pc = s.rdat1; m_valid = 0;
            end else if (m_valid && (s.jump || s.jal)) begin
                m_pc = {m_npc[31:28], s.jaddr, 2'b00}; m_valid = 0;
            end else if (m_valid && s.branch && ((s.beq && s.zero) || (s.bne && !s.zero))) begin
                off = int'($signed(s.imm16)) * 4;
                m_pc = m_npc + word_t'(off); m_valid = 0;
            end else if (s.ihit) begin
                sb_q.push_back('{instr: mem_word(m_pc), npc: m_pc + 32'd4});
                m_npc = m_pc + 32'd4; m_pc = m_pc + 32'd4; m_valid = 1;
`ifdef FETCH_STATS_EN
                m_fetch = m_fetch + 1;
`endif
            end else begin
                m_valid = 0;
            end
        end

        @(negedge clk);
        check32("imemaddr", bus.imemaddr, m_pc);
        check32("imemREN", 32'(bus.imemREN), 32'(!m_halted));
        check32("halted", 32'(bus.halted), 32'(m_halted));
        check32("valid_id", 32'(bus.valid_id), 32'(m_valid));
`ifdef FETCH_STATS_EN
        check32("fetch_cnt", bus.fetch_cnt, m_fetch);
        check32("miss_cnt", bus.miss_cnt, m_miss);
`endif
    endtask

    function automatic stim_t hit();
        stim_t s = idle();
        s.ihit = 1;
        return s;
    endfunction

    function automatic stim_t rst_stim();
        stim_t s = idle();
        s.rst = 1;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s = idle();
        word_t r;
        s.ihit  = ($urandom_range(99) < 75);
        s.stall = ($urandom_range(99) < 15);
        s.zero  = 1'($urandom_range(1));
        s.imm16 = 16'($urandom());
        s.jaddr = 26'($urandom());
        r = $urandom();
        if ($urandom_range(9) < 8) r[1:0] = 2'b00;
        s.rdat1 = r;
        case ($urandom_range(15))
            0: s.jr = 1;
            1: s.jump = 1;
            2: s.jal = 1;
            3: begin s.branch = 1; s.beq = 1; end
            4: begin s.branch = 1; s.bne = 1; end
            5: s.beq = 1;
            6: begin s.jr = 1; s.jump = 1; end
            default: ;
        endcase
        s.halt = ($urandom_range(149) == 0);
        s.rst  = m_halted ? ($urandom_range(9) == 0) : ($urandom_range(499) == 0);
        return s;
    endfunction

    // Monitor: each edge that loads a new valid instruction must match the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && !bus.stall && bus.valid_id) begin
                if (sb_q.size() == 0) begin
                    check32("sb_unexpected_valid", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    check32("sb_instr_id", bus.instr_id, e.instr);
                    check32("sb_npc_id", bus.npc_id, e.npc);
                end
            end
        end
    end

    initial begin
        stim_t s;
        word_t frozen;
        bus.ihit = 0; bus.stall = 0; bus.branch = 0; bus.beq = 0; bus.bne = 0;
        bus.jump = 0; bus.jal = 0; bus.jr = 0; bus.halt = 0; bus.zero = 0;
        bus.imm16 = '0; bus.jaddr = '0; bus.rdat1 = '0; bus.imemload = '0;
        @(negedge clk);

        // Reset state.
        step(rst_stim());
        check32("reset_pc", bus.imemaddr, 32'h0);
        check32("reset_instr_id", bus.instr_id, 32'h0);
        check32("reset_npc_id", bus.npc_id, 32'h0);

        // Three back-to-back hits.
        for (int k = 1; k <= 3; k++) begin
            step(hit());
            check32("seq_pc", bus.imemaddr, word_t'(4 * k));
            check32("seq_npc_id", bus.npc_id, word_t'(4 * k));
        end

        // Two misses at PC=8, then the hit.
        step(rst_stim());
        step(hit());
        step(hit());
        for (int k = 0; k < 2; k++) begin
            step(idle());
            check32("miss_pc_hold", bus.imemaddr, 32'h8);
            check32("miss_bubble", 32'(bus.valid_id), 32'h0);
        end
        step(hit());
        check32("miss_then_instr", bus.instr_id, mem_word(32'h8));
        check32("miss_then_pc", bus.imemaddr, 32'hC);

        // Taken beq backward to 0x08, then the not-taken variant.
        step(rst_stim());
        for (int k = 0; k < 4; k++) step(hit());
        s = hit(); s.branch = 1; s.beq = 1; s.zero = 1; s.imm16 = 16'hFFFE;
        step(s);
        check32("beq_taken_pc", bus.imemaddr, 32'h8);
        check32("beq_taken_squash", 32'(bus.valid_id), 32'h0);
        step(rst_stim());
        for (int k = 0; k < 4; k++) step(hit());
        s.zero = 0;
        step(s);
        check32("beq_not_taken_pc", bus.imemaddr, 32'h14);

        // jr + jump under stall, released after two cycles.
        s = hit(); s.jr = 1; s.jump = 1; s.rdat1 = 32'h400; s.jaddr = 26'h3; s.stall = 1;
        step(s);
        step(s);
        check32("stall_pc_hold", bus.imemaddr, 32'h14);
        s.stall = 0;
        step(s);
        check32("jr_target", bus.imemaddr, 32'h400);

        // PC wrap at the top of the address space.
        step(hit());
        s = hit(); s.jr = 1; s.rdat1 = 32'hFFFF_FFFC;
        step(s);
        step(hit());
        check32("wrap_pc", bus.imemaddr, 32'h0);

        // Halt freezes everything until reset.
        s = hit(); s.halt = 1;
        step(s);
        frozen = bus.imemaddr;
        for (int k = 0; k < 10; k++) begin
            s = rand_stim(); s.rst = 0;
            step(s);
            check32("halt_pc_frozen", bus.imemaddr, frozen);
        end
        step(rst_stim());
        check32("halt_reset_pc", bus.imemaddr, TB_PC_INIT);

`ifdef FETCH_STATS_EN
        // Five hits, three misses, then halt.
        step(rst_stim());
        step(hit()); step(idle()); step(hit()); step(idle());
        step(hit()); step(idle()); step(hit()); step(hit());
        s = hit(); s.halt = 1;
        step(s);
        for (int k = 0; k < 5; k++) step(idle());
        check32("stats_fetch", bus.fetch_cnt, 32'd5);
        check32("stats_miss", bus.miss_cnt, 32'd3);
`endif

        // Randomized traffic.
        step(rst_stim());
        for (int k = 0; k < 3000; k++) step(rand_stim());

        step(idle());
        check32("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
